// File: rtl/face_selector.sv
// face_selector: turns the pet's status levels into the face index for the
// 16x2 LCD custom-character painter. A committed face is held for a minimum
// time so the slow repaint is not thrashed. The death face is sticky and
// bypasses the hold.
// Optional idle blink: define FACE_SEL_BLINK_EN to build the blink timer and
// the BLINK state. Without it, blinking is tied low and face 8 never appears.
`timescale 1ns/1ps

module face_selector #(
   parameter int QUANTITY_CUSTOM_CHAR = 9,
   parameter int LEVEL_W              = 3,
   parameter int LOW_THRESH           = 2,
   parameter int HIGH_THRESH          = 6,
   parameter int HOLD_CYCLES          = 50_000_000,
   parameter int BLINK_PERIOD         = 150_000_000,
   parameter int BLINK_LEN            = 12_500_000
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [LEVEL_W-1:0]                      hunger_lvl,
   input  logic [LEVEL_W-1:0]                      energy_lvl,
   input  logic [LEVEL_W-1:0]                      happy_lvl,
   input  logic [LEVEL_W-1:0]                      health_lvl,
   input  logic                                    sleeping,
   input  logic                                    dead,
   output logic [$clog2(QUANTITY_CUSTOM_CHAR)-1:0] face_idx,
   output logic                                    face_changed,
   output logic                                    blinking
);

   localparam int FACE_W = $clog2(QUANTITY_CUSTOM_CHAR);

   localparam logic [FACE_W-1:0] FACE_NEUTRAL = FACE_W'(0);
   localparam logic [FACE_W-1:0] FACE_HAPPY   = FACE_W'(1);
   localparam logic [FACE_W-1:0] FACE_SAD     = FACE_W'(2);
   localparam logic [FACE_W-1:0] FACE_HUNGRY  = FACE_W'(3);
   localparam logic [FACE_W-1:0] FACE_TIRED   = FACE_W'(4);
   localparam logic [FACE_W-1:0] FACE_SLEEP   = FACE_W'(5);
   localparam logic [FACE_W-1:0] FACE_SICK    = FACE_W'(6);
   localparam logic [FACE_W-1:0] FACE_DEAD    = FACE_W'(7);

   localparam logic [LEVEL_W-1:0] LOW_LVL  = LEVEL_W'(LOW_THRESH);
   localparam logic [LEVEL_W-1:0] HIGH_LVL = LEVEL_W'(HIGH_THRESH);

   localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_SHOW,
      ST_READY,
      ST_BLINK
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [FACE_W-1:0]   r_face_idx;
   logic [FACE_W-1:0]   w_face_nxt;
   logic                r_face_chg;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic [HOLD_W-1:0]   w_hold_nxt;
   logic [FACE_W-1:0]   r_cand_q;
   logic [FACE_W-1:0]   w_cand;
   logic                r_dead_lat;

`ifdef FACE_SEL_BLINK_EN
   localparam int                 BLINK_W    = $clog2(BLINK_PERIOD);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);
   localparam logic [BLINK_W-1:0] WIN_START  = BLINK_W'(BLINK_PERIOD - BLINK_LEN);

   logic [BLINK_W-1:0] r_blink_cnt;
   logic               w_window;

   // Free-running blink timer, wraps at BLINK_PERIOD-1.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_blink_cnt <= '0;
      end else if (r_blink_cnt == BLINK_LAST) begin
         r_blink_cnt <= '0;
      end else begin
         r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
   end

   assign w_window = (r_blink_cnt >= WIN_START);
   assign blinking = (r_state == ST_BLINK);
`else
   logic w_unused_blink_cfg;

   assign w_unused_blink_cfg = (BLINK_PERIOD > BLINK_LEN);
   assign blinking           = 1'b0;
`endif

   // Priority map from status levels to the candidate face.
   always_comb begin
      w_cand = FACE_NEUTRAL;
      if (r_dead_lat || dead) begin
         w_cand = FACE_DEAD;
      end else if (sleeping) begin
         w_cand = FACE_SLEEP;
      end else if (health_lvl <= LOW_LVL) begin
         w_cand = FACE_SICK;
      end else if (hunger_lvl <= LOW_LVL) begin
         w_cand = FACE_HUNGRY;
      end else if (energy_lvl <= LOW_LVL) begin
         w_cand = FACE_TIRED;
      end else if (happy_lvl <= LOW_LVL) begin
         w_cand = FACE_SAD;
      end else if (happy_lvl >= HIGH_LVL) begin
         w_cand = FACE_HAPPY;
      end
   end

   // Sticky death latch and registered candidate.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_dead_lat <= 1'b0;
         r_cand_q   <= FACE_NEUTRAL;
      end else begin
         r_dead_lat <= r_dead_lat | dead;
         r_cand_q   <= w_cand;
      end
   end

   // Next-state, next-face and hold-counter decisions; the death override
   // is checked ahead of the per-state rules so it bypasses any hold.
   always_comb begin
      w_state_nxt = r_state;
      w_face_nxt  = r_face_idx;
      w_hold_nxt  = r_hold_cnt;
      if (r_cand_q == FACE_DEAD && r_face_idx != FACE_DEAD) begin
         w_face_nxt  = r_cand_q;
         w_hold_nxt  = HOLD_LOAD;
         w_state_nxt = ST_SHOW;
      end else begin
         case (r_state)
            ST_SHOW: begin
               if (r_hold_cnt == '0) begin
                  w_state_nxt = ST_READY;
               end else begin
                  w_hold_nxt = r_hold_cnt - HOLD_W'(1);
               end
            end
            ST_READY: begin
               if (r_cand_q != r_face_idx) begin
                  w_face_nxt  = r_cand_q;
                  w_hold_nxt  = HOLD_LOAD;
                  w_state_nxt = ST_SHOW;
`ifdef FACE_SEL_BLINK_EN
               end else if (w_window && r_face_idx == FACE_NEUTRAL) begin
                  w_face_nxt  = FACE_W'(8);
                  w_state_nxt = ST_BLINK;
`endif
               end
            end
`ifdef FACE_SEL_BLINK_EN
            ST_BLINK: begin
               if (r_cand_q != FACE_NEUTRAL) begin
                  w_face_nxt  = r_cand_q;
                  w_hold_nxt  = HOLD_LOAD;
                  w_state_nxt = ST_SHOW;
               end else if (!w_window) begin
                  w_face_nxt  = FACE_NEUTRAL;
                  w_state_nxt = ST_READY;
               end
            end
`endif
            default: begin
               w_state_nxt = ST_SHOW;
            end
         endcase
      end
   end

   // State, face and hold registers; face_changed flags any value change.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_SHOW;
         r_face_idx <= FACE_NEUTRAL;
         r_face_chg <= 1'b0;
         r_hold_cnt <= HOLD_LOAD;
      end else begin
         r_state    <= w_state_nxt;
         r_face_idx <= w_face_nxt;
         r_face_chg <= (w_face_nxt != r_face_idx);
         r_hold_cnt <= w_hold_nxt;
      end
   end

   assign face_idx     = r_face_idx;
   assign face_changed = r_face_chg;

endmodule

// File: doc/face_selector.md
Name: face_selector

Overview:
- Upstream stage of the 16x2 LCD custom-character painter. It converts the pet's status levels into the face index that the painter consumes on its num_cust_char input.
- Applies a fixed priority map and a minimum hold time, so the slow LCD repaint (one command per ~16 ms enable) is not thrashed.
- Adds a periodic idle blink and a sticky death face.

Parameters:
- QUANTITY_CUSTOM_CHAR, 9, number of faces in the painter's face table; output width is $clog2(QUANTITY_CUSTOM_CHAR).
- LEVEL_W, 3, width of each status level input.
- LOW_THRESH, 2, level <= LOW_THRESH counts as "low".
- HIGH_THRESH, 6, happy_lvl >= HIGH_THRESH counts as "happy".
- HOLD_CYCLES, 50_000_000, minimum clk cycles a committed face stays on the output (1 s at 50 MHz).
- BLINK_PERIOD, 150_000_000, blink timer period in clk cycles.
- BLINK_LEN, 12_500_000, blink window length in cycles; the window is the last BLINK_LEN counts of each period. Must be < BLINK_PERIOD.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low.
- hunger_lvl  input  LEVEL_W  satiety level (0 = starving).
- energy_lvl  input  LEVEL_W  energy level.
- happy_lvl  input  LEVEL_W  happiness level.
- health_lvl  input  LEVEL_W  health level.
- sleeping  input  1  pet asleep.
- dead  input  1  pet died; sampled and latched.
- face_idx  output  $clog2(QUANTITY_CUSTOM_CHAR)  face index to the LCD painter.
- face_changed  output  1  one-cycle pulse in the cycle face_idx takes a new value.
- blinking  output  1  high while in BLINK state.

Behaviour:
- Face codes: 0 NEUTRAL, 1 HAPPY, 2 SAD, 3 HUNGRY, 4 TIRED, 5 SLEEP, 6 SICK, 7 DEAD, 8 BLINK.
- Reset (reset==0 at posedge clk) values:
  - face_idx=0, face_changed=0, blinking=0.
  - dead_lat=0, cand_q=0, hold_cnt=HOLD_CYCLES-1, blink_cnt=0, state=SHOW.
- Reset mid-operation aborts any hold or blink immediately.
- dead_lat is set on any cycle with dead==1 and clears only on reset.
- Candidate selection is combinational. The first matching rule wins:
  1. dead_lat or dead → DEAD.
  2. sleeping → SLEEP.
  3. health <= LOW → SICK.
  4. hunger <= LOW → HUNGRY.
  5. energy <= LOW → TIRED.
  6. happy <= LOW → SAD.
  7. happy >= HIGH → HAPPY.
  8. Otherwise NEUTRAL.
- The candidate is registered into cand_q, so input-to-cand_q latency is 1 cycle.
- Commit: face_idx <= cand_q, face_changed <= 1, hold_cnt <= HOLD_CYCLES-1, state <= SHOW.
  - Input change to face_idx change is 2 cycles minimum when the change is not blocked by hold.
- State machine:
  - SHOW: hold_cnt decrements each cycle; when hold_cnt==0, go to READY. Input changes during SHOW are not committed, except DEAD.
  - READY:
    - If cand_q != face_idx, commit.
    - Else, if the blink window is active and face_idx==NEUTRAL: face_idx <= BLINK, face_changed=1, blinking=1, go to BLINK.
  - BLINK:
    - If cand_q != NEUTRAL, commit cand_q; this takes precedence over the window ending.
    - Else, when the blink window ends: face_idx <= NEUTRAL, face_changed=1, blinking=0, go to READY (no hold reload).
- DEAD override: in any state, if cand_q==DEAD and face_idx!=DEAD, commit immediately, ignoring hold. Once face_idx is DEAD it never changes until reset (dead_lat is sticky).
- Blink timer: blink_cnt free-runs 0..BLINK_PERIOD-1 and wraps to 0. The window is active when blink_cnt >= BLINK_PERIOD-BLINK_LEN.
  - A window that opens while in SHOW is missed until the next period, unless READY is reached while the window is still active (it is then honoured for the remainder).
- Simultaneous events:
  - Commit and blink entry in the same READY cycle: commit wins.
  - hold_cnt reaching 0 and a candidate change in the same cycle: transition to READY; commit on the following cycle.
- face_changed is never asserted when the new value equals the old one.
- face_idx never exceeds 8.
- Counter widths are $clog2 of their maxima; no overflow is possible.

Optional Feature:
- FACE_SEL_BLINK_EN.
- Defined: blink timer, BLINK state and blinking output behave as above.
- Undefined:
  - The blink counter and BLINK state are not built; blinking is tied to 0.
  - READY only commits, and face 8 is never produced.
  - All other timing is identical.

Test Plan:
Test parameters: HOLD_CYCLES=10, BLINK_PERIOD=40, BLINK_LEN=4, macro defined unless noted.
- Reset with mid-level inputs (all levels 4) → face_idx=0, face_changed=0, blinking=0. The first blink appears at blink_cnt=36 (face 8), and face 0 returns at wrap.
- After hold expires, drop hunger_lvl to 1 at cycle T → face_idx=3 at T+2 with a one-cycle face_changed. Raising hunger to 4 at T+3 → face_idx stays 3 until the hold expires (10 cycles after commit), then becomes 0 two cycles later at most.
- hunger_lvl=1 and sleeping=1 together → face 5; also set health_lvl=0 → still 5 (priority).
- During SHOW of face 1, pulse dead for one cycle → face_idx=7 two cycles later, regardless of hold. Levels returning to 4 → face stays 7 until reset, then 0.
- In BLINK (face 8), set happy_lvl=7 → next commit gives face 1 with blinking=0, and the window end causes no further change.
- Macro undefined, run 200 cycles with neutral inputs → face_idx constant 0, blinking=0, face_changed never asserted.
